// File: rtl/key_pkg.sv
// Shared types and helpers for the push-button debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } key_state_t;

  // Bits needed to hold values 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One push-button channel: 2-flop synchroniser, debounce FSM, strobe registers.
// Optional auto-repeat strobe when KEY_REPEAT_EN is defined (requires REP_PERIOD <= REP_DELAY).
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = 1_000_000
`ifdef KEY_REPEAT_EN
  ,
  parameter int unsigned REP_DELAY  = 25_000_000,
  parameter int unsigned REP_PERIOD = 5_000_000
`endif
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic key_n,
  output logic lvl,
  output logic press,
  output logic rel,
  output logic rep
);

  localparam int unsigned CW = cnt_w(DB_CYCLES);

  logic [1:0]    sync;
  logic          s_key;
  key_state_t    state;
  key_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] cnt_inc;
  logic          wait_done;
  logic          lvl_nxt;
  logic          press_nxt;
  logic          rel_nxt;

  assign s_key     = sync[1];
  assign cnt_inc   = (cnt == CW'(DB_CYCLES)) ? cnt : cnt + 1'b1;
  assign wait_done = (cnt == CW'(DB_CYCLES - 1));

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sync <= 2'b11;
    else        sync <= {sync[0], key_n};
  end

  // FSM state and debounce counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: any bounce inside a wait window restarts from the stable side.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (!s_key) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (s_key) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (wait_done) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      HELD: begin
        if (s_key) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!s_key) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (wait_done) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the transition being taken this cycle.
  always_comb begin
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    lvl_nxt   = 1'b0;
    if ((state == PRESS_WAIT) && (state_nxt == HELD)) press_nxt = 1'b1;
    if ((state == RELEASE_WAIT) && (state_nxt == IDLE)) rel_nxt = 1'b1;
    if ((state_nxt == HELD) || (state_nxt == RELEASE_WAIT)) lvl_nxt = 1'b1;
  end

  // Registered level and strobes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lvl   <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      lvl   <= lvl_nxt;
      press <= press_nxt;
      rel   <= rel_nxt;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned RCW = cnt_w(REP_DELAY);

  logic [RCW-1:0] rcnt;
  logic           stay_held;
  logic           rep_hit;

  assign stay_held = (state == HELD) && (state_nxt == HELD);
  assign rep_hit   = stay_held && (rcnt == RCW'(REP_DELAY - 1));

  // Hold-time counter; reloads after each repeat so later strobes come every REP_PERIOD.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rcnt <= '0;
      rep  <= 1'b0;
    end else begin
      rep <= rep_hit;
      if (!stay_held)   rcnt <= '0;
      else if (rep_hit) rcnt <= RCW'(REP_DELAY - REP_PERIOD);
      else              rcnt <= rcnt + 1'b1;
    end
  end
`else
  assign rep = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Debounces N_KEYS active-low push-buttons into clean levels and press/release strobes.
// Define KEY_REPEAT_EN to add the auto-repeat strobe and its REP_DELAY/REP_PERIOD parameters.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS     = 4,
  parameter int unsigned DB_CYCLES  = 1_000_000
`ifdef KEY_REPEAT_EN
  ,
  parameter int unsigned REP_DELAY  = 25_000_000,
  parameter int unsigned REP_PERIOD = 5_000_000
`endif
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [N_KEYS-1:0] KEY_N,
  output logic [N_KEYS-1:0] KEY_LVL,
  output logic [N_KEYS-1:0] KEY_PRESS,
  output logic [N_KEYS-1:0] KEY_RELEASE,
  output logic [N_KEYS-1:0] KEY_REPEAT
);

  // One independent channel per key.
  for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_key
    key_debounce_ch #(
      .DB_CYCLES  (DB_CYCLES)
`ifdef KEY_REPEAT_EN
      ,
      .REP_DELAY  (REP_DELAY),
      .REP_PERIOD (REP_PERIOD)
`endif
    ) u_ch (
      .CLK   (CLK),
      .RST_N (RST_N),
      .key_n (KEY_N[i]),
      .lvl   (KEY_LVL[i]),
      .press (KEY_PRESS[i]),
      .rel   (KEY_RELEASE[i]),
      .rep   (KEY_REPEAT[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus randomized key activity,
// checked every cycle against a run-length model of the debouncer.
module tb_key_debounce;

  localparam int N  = 4;
  localparam int DB = 8;
`ifdef KEY_REPEAT_EN
  localparam int RD = 20;
  localparam int RP = 5;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] key_n = '1;
  logic [N-1:0] lvl;
  logic [N-1:0] press;
  logic [N-1:0] rel;
  logic [N-1:0] rep;

  int errors = 0;
  int checks = 0;

  key_debounce #(
    .N_KEYS     (N),
    .DB_CYCLES  (DB)
`ifdef KEY_REPEAT_EN
    ,
    .REP_DELAY  (RD),
    .REP_PERIOD (RP)
`endif
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .KEY_N       (key_n),
    .KEY_LVL     (lvl),
    .KEY_PRESS   (press),
    .KEY_RELEASE (rel),
    .KEY_REPEAT  (rep)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the key state seen by the debouncer lags the pin by two
  // samples; the accepted level flips once DB+1 consecutive samples disagree with it.
  bit           d1 [N];
  bit           d2 [N];
  bit           m_acc [N];
  int           m_run [N];
  logic [N-1:0] m_lvl, m_press, m_rel, m_rep;
  bit           pn;
`ifdef KEY_REPEAT_EN
  int           m_hold [N];
  bit           steady;
`endif

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < N; k++) begin
          d1[k] = 1'b1; d2[k] = 1'b1; m_acc[k] = 1'b0; m_run[k] = 0;
`ifdef KEY_REPEAT_EN
          m_hold[k] = 0;
`endif
        end
        m_lvl = '0; m_press = '0; m_rel = '0; m_rep = '0;
      end else begin
        m_press = '0; m_rel = '0; m_rep = '0;
        for (int k = 0; k < N; k++) begin
          pn    = !d2[k];
          d2[k] = d1[k];
          d1[k] = key_n[k];
`ifdef KEY_REPEAT_EN
          steady = m_acc[k] && (m_run[k] == 0);
`endif
          if (pn != m_acc[k]) m_run[k]++;
          else                m_run[k] = 0;
          if (m_run[k] == DB + 1) begin
            m_acc[k] = pn;
            m_run[k] = 0;
            if (pn) m_press[k] = 1'b1;
            else    m_rel[k]   = 1'b1;
          end
`ifdef KEY_REPEAT_EN
          if (steady && pn) begin
            m_hold[k]++;
            if (m_hold[k] == RD || (m_hold[k] > RD && (m_hold[k] - RD) % RP == 0))
              m_rep[k] = 1'b1;
          end else begin
            m_hold[k] = 0;
          end
`endif
          m_lvl[k] = m_acc[k];
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      chk("cyc_lvl",     32'(lvl),   32'(m_lvl));
      chk("cyc_press",   32'(press), 32'(m_press));
      chk("cyc_release", 32'(rel),   32'(m_rel));
      chk("cyc_repeat",  32'(rep),   32'(m_rep));
      chk("cyc_excl",    32'(press & rel), 32'd0);
    end
  end

  int cnt_a, pos_a, any_a, first_r, last_r, late_r;
  int dwell [N];

  initial begin : stim
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_lvl",   32'(lvl),   32'd0);
    chk("reset_press", 32'(press), 32'd0);
    chk("reset_rel",   32'(rel),   32'd0);
    chk("reset_rep",   32'(rep),   32'd0);
    rst_n = 1'b1;
    tick();

    // Clean press on key 0.
    key_n[0] = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i >= 10 && i <= 12) chk("t1_press0", 32'(press[0]), 32'(i == 11));
      if (i == 11) begin
        chk("t1_model_press0", 32'(m_press[0]), 32'd1);
        chk("t1_lvl0", 32'(lvl[0]), 32'd1);
      end
      if (i == 30) chk("t1_lvl_all", 32'(lvl), 32'b0001);
    end

    // Bouncing key 1, settles low.
    cnt_a = 0; pos_a = -1;
    for (int s = 0; s < 8; s++) begin
      key_n[1] = (s % 2 == 1);
      repeat (3) begin
        tick();
        if (press[1] || rel[1]) cnt_a++;
      end
    end
    key_n[1] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (press[1]) begin cnt_a++; pos_a = i; end
      if (i == 11) chk("t2_model_press1", 32'(m_press[1]), 32'd1);
    end
    chk("t2_press_count", 32'(cnt_a), 32'd1);
    chk("t2_press_pos",   32'(pos_a), 32'd11);

    // Short glitch on key 2.
    any_a = 0;
    key_n[2] = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      if (i == 6) key_n[2] = 1'b1;
      tick();
      if (press[2] || rel[2] || lvl[2]) any_a++;
      if (m_press[2] || m_lvl[2]) any_a += 100;
    end
    chk("t3_glitch_activity", 32'(any_a), 32'd0);

    // Release key 0.
    key_n[0] = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i >= 10 && i <= 12) chk("t4_rel0", 32'(rel[0]), 32'(i == 11));
      if (i == 11) begin
        chk("t4_model_rel0", 32'(m_rel[0]), 32'd1);
        chk("t4_press0", 32'(press[0]), 32'd0);
      end
      if (i == 12) chk("t4_lvl0", 32'(lvl[0]), 32'd0);
    end

    // Reset during key 3 debounce, with key 1 still held.
    key_n[3] = 1'b0;
    repeat (7) tick();
    chk("t5_pre_reset_lvl", 32'(lvl), 32'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_lvl",   32'(lvl),   32'd0);
    chk("t5_async_press", 32'(press), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 10) chk("t5_press_early", 32'(press), 32'd0);
      if (i == 11) begin
        chk("t5_press",       32'(press),   32'b1010);
        chk("t5_model_press", 32'(m_press), 32'b1010);
        chk("t5_lvl",         32'(lvl),     32'b1010);
      end
    end
    key_n = '1;
    repeat (15) tick();
    chk("t5_all_released", 32'(lvl), 32'd0);

    // Long hold on key 3 for the auto-repeat path.
    cnt_a = 0; first_r = -1; last_r = -1; late_r = 0; pos_a = -1;
    key_n[3] = 1'b0;
    for (int i = 1; i <= 95; i++) begin
      if (i == 61) key_n[3] = 1'b1;
      tick();
      if (press[3]) pos_a = i;
      if (rep[3]) begin
        cnt_a++;
        if (first_r < 0) first_r = i;
        last_r = i;
        if (i > 71) late_r++;
      end
`ifdef KEY_REPEAT_EN
      if (i == 31) chk("t6_model_rep3", 32'(m_rep[3]), 32'd1);
`endif
    end
    chk("t6_press_pos", 32'(pos_a), 32'd11);
`ifdef KEY_REPEAT_EN
    chk("t6_rep_count", 32'(cnt_a),   32'd7);
    chk("t6_rep_first", 32'(first_r), 32'd31);
    chk("t6_rep_last",  32'(last_r),  32'd61);
    chk("t6_rep_late",  32'(late_r),  32'd0);
`else
    chk("t6_rep_count", 32'(cnt_a), 32'd0);
`endif

    // Randomized activity on all keys, with one reset in the middle.
    for (int k = 0; k < N; k++) dwell[k] = int'($urandom_range(1, 30));
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) rst_n = 1'b0;
      if (c == 1503) rst_n = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (dwell[k] == 0) begin
          key_n[k] = ~key_n[k];
          dwell[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                                 : int'($urandom_range(6, 40));
        end else begin
          dwell[k]--;
        end
      end
      tick();
    end

    key_n = '1;
    repeat (20) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
